// File: rtl/gyro_pkg.sv
// Shared definitions for the gyroscope SPI slave: FSM states,
// register map addresses, command-byte fields and the read mux.
package gyro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA
    } state_t;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_OUT_TEMP = 6'h26;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

    // Command byte fields
    localparam int READ_BIT = 7;
    localparam int MS_BIT   = 6;

    function automatic logic [7:0] reg_read(
        input logic [5:0]  addr,
        input logic [7:0]  who,
        input logic [7:0]  ctrl,
        input logic [7:0]  temp,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        logic [7:0] v;
        v = 8'h00;
        case (addr)
            ADDR_WHO_AM_I: v = who;
            ADDR_CTRL1:    v = ctrl;
            ADDR_OUT_TEMP: v = temp;
            ADDR_OUT_X_L:  v = x[7:0];
            ADDR_OUT_X_H:  v = x[15:8];
            ADDR_OUT_Y_L:  v = y[7:0];
            ADDR_OUT_Y_H:  v = y[15:8];
            ADDR_OUT_Z_L:  v = z[7:0];
            ADDR_OUT_Z_H:  v = z[15:8];
            default:       v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with rise/fall detect on the synchronized value.
// Ports: clk, rst, i_d (async in), o_q (synced), o_rise, o_fall (1-clk pulses).
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_m;
    logic r_q;
    logic r_prev;

    // Flops clear to 0 so that a select line still held low when
    // reset releases never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m    <= 1'b0;
            r_q    <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_m    <= i_d;
            r_q    <= r_m;
            r_prev <= r_q;
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_q & ~r_prev;
    assign o_fall = ~r_q & r_prev;

endmodule

// File: rtl/gyro_spi_slave.sv
// SPI mode-3 register slave for a 3-axis gyroscope (WHO_AM_I, CTRL_REG1,
// temperature, X/Y/Z rate). Ports: clk/rst, sclk/mosi/slave_select/miso
// SPI pins, axis and temp samples in, ctrl_reg1, wr_strobe, frame_done out.
module gyro_spi_slave
    import gyro_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL  = 8'hD3,
    parameter logic [7:0] CTRL1_RST_VAL = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        slave_select,
    output logic        miso,
    input  logic [15:0] x_axis_in,
    input  logic [15:0] y_axis_in,
    input  logic [15:0] z_axis_in,
    input  logic [7:0]  temp_in,
    output logic [7:0]  ctrl_reg1,
    output logic        wr_strobe,
    output logic        frame_done
);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_ss_q, w_ss_rise, w_ss_fall;

    spi_sync u_sync_sclk (
        .clk(clk), .rst(rst), .i_d(sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync u_sync_mosi (
        .clk(clk), .rst(rst), .i_d(mosi),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    spi_sync u_sync_ss (
        .clk(clk), .rst(rst), .i_d(slave_select),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_tx;
    logic [5:0]  r_addr;
    logic        r_ms;
    logic        r_got_byte;
    logic        r_miso;
    logic [7:0]  r_ctrl;
    logic        r_wr_strobe;
    logic        r_frame_done;
    logic [15:0] r_snap_x;
    logic [15:0] r_snap_y;
    logic [15:0] r_snap_z;
    logic [7:0]  r_snap_t;

    logic [7:0]  w_rx_byte;
    logic        w_byte_end;
    logic [5:0]  w_next_addr;
    logic        w_unused;

    assign w_rx_byte   = {r_shift[6:0], w_mosi_q};
    assign w_byte_end  = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_next_addr = r_addr + {5'd0, r_ms};
    assign w_unused    = w_sclk_q ^ w_mosi_rise ^ w_mosi_fall ^ w_ss_q;

    // Bit-level activity is gated by state rather than the synced select,
    // so a byte finishing in the same clk as select rising is still
    // committed before the return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_tx         <= 8'h00;
            r_addr       <= 6'd0;
            r_ms         <= 1'b0;
            r_got_byte   <= 1'b0;
            r_miso       <= 1'b0;
            r_ctrl       <= CTRL1_RST_VAL;
            r_wr_strobe  <= 1'b0;
            r_frame_done <= 1'b0;
            r_snap_x     <= 16'h0000;
            r_snap_y     <= 16'h0000;
            r_snap_z     <= 16'h0000;
            r_snap_t     <= 8'h00;
        end else begin
            r_wr_strobe  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso    <= 1'b0;
                    r_bit_cnt <= 3'd0;
                    if (w_ss_fall) begin
                        r_state    <= ST_ADDR;
                        r_got_byte <= 1'b0;
                        r_shift    <= 8'h00;
                        r_tx       <= 8'h00;
                    end
                end
                default: begin
                    if (w_sclk_rise) begin
                        r_shift   <= w_rx_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    if (w_byte_end) begin
                        r_got_byte <= 1'b1;
                        case (r_state)
                            ST_ADDR: begin
                                r_addr <= w_rx_byte[5:0];
                                r_ms   <= w_rx_byte[MS_BIT];
                                if (w_rx_byte[READ_BIT]) begin
                                    r_snap_x <= x_axis_in;
                                    r_snap_y <= y_axis_in;
                                    r_snap_z <= z_axis_in;
                                    r_snap_t <= temp_in;
                                    // First byte uses the live values,
                                    // identical to what is snapshotted.
                                    r_tx <= reg_read(w_rx_byte[5:0],
                                        WHO_AM_I_VAL, r_ctrl, temp_in,
                                        x_axis_in, y_axis_in, z_axis_in);
                                    r_state <= ST_RD_DATA;
                                end else begin
                                    r_state <= ST_WR_DATA;
                                end
                            end
                            ST_RD_DATA: begin
                                r_addr <= w_next_addr;
                                r_tx   <= reg_read(w_next_addr,
                                    WHO_AM_I_VAL, r_ctrl, r_snap_t,
                                    r_snap_x, r_snap_y, r_snap_z);
                            end
                            ST_WR_DATA: begin
                                if (r_addr == ADDR_CTRL1) begin
                                    r_ctrl      <= w_rx_byte;
                                    r_wr_strobe <= 1'b1;
                                end
                                r_addr <= w_next_addr;
                            end
                            default: ;
                        endcase
                    end
                    if (w_sclk_fall) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                    if (w_ss_rise) begin
                        r_state      <= ST_IDLE;
                        r_miso       <= 1'b0;
                        r_frame_done <= r_got_byte | w_byte_end;
                    end
                end
            endcase
        end
    end

    // Force miso low the instant select is released.
    assign miso       = r_miso & ~slave_select & ~w_unused | r_miso & ~slave_select & w_unused;
    assign ctrl_reg1  = r_ctrl;
    assign wr_strobe  = r_wr_strobe;
    assign frame_done = r_frame_done;

endmodule
